// File: rtl/elev_req_ctrl_if.sv
// Bundle between the elevator request controller and its environment.
// u/d are single-cycle command pulses with no back-pressure; call and floor are plain levels.
interface elev_req_ctrl_if;
  logic [3:0] call;
  logic [1:0] floor;
  logic       u;
  logic       d;
  logic [3:0] pending;
  logic       door_open;
  logic       dir_up;
  logic [1:0] state;

  modport master (
    output call, floor,
    input  u, d, pending, door_open, dir_up, state
  );

  modport slave (
    input  call, floor,
    output u, d, pending, door_open, dir_up, state
  );
endinterface

// File: rtl/elev_req_ctrl.sv
// Elevator request latch and sweep controller (IDLE/DOOR/STEP/SETTLE).
// Optional macro ELEV_REQ_CTRL_CALL_SYNC_EN adds a 2-flop synchronizer on call.
module elev_req_ctrl #(
  parameter int unsigned DWELL_CYCLES = 8,
  parameter int unsigned STEP_CYCLES  = 4
) (
  input  logic           clk,
  input  logic           rst,
  elev_req_ctrl_if.slave bus
);
  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_DOOR   = 2'd1;
  localparam logic [1:0] S_STEP   = 2'd2;
  localparam logic [1:0] S_SETTLE = 2'd3;

  localparam logic [7:0] DWELL_LD = 8'(DWELL_CYCLES);
  localparam logic [7:0] STEP_LD  = 8'(STEP_CYCLES);

  logic [1:0] state_q, state_n;
  logic [7:0] cnt_q, cnt_n;
  logic [3:0] pend_q, pend_n;
  logic       dir_q, dir_n;
  logic       u_q, d_q, door_q;
  logic [3:0] call_c, prev_q, armed_q, call_edge;
  logic [3:0] set_mask, clr_mask;
  logic [3:0] floor_bit, above_mask, below_mask;
  logic       hit, has_above, has_below, move_ok;

`ifdef ELEV_REQ_CTRL_CALL_SYNC_EN
  logic [3:0] sync1_q, sync2_q;

  always_ff @(posedge clk) begin
    if (!rst) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= bus.call;
      sync2_q <= sync1_q;
    end
  end

  assign call_c = sync2_q;
`else
  assign call_c = bus.call;
`endif

  // armed_q only goes high once a call bit has been seen low after reset,
  // so a button held through reset needs a release before it counts.
  assign call_edge = call_c & ~prev_q & armed_q;

  assign floor_bit = 4'b0001 << bus.floor;

  always_comb begin
    above_mask = 4'b0000;
    below_mask = 4'b0000;
    case (bus.floor)
      2'd0: begin above_mask = 4'b1110; below_mask = 4'b0000; end
      2'd1: begin above_mask = 4'b1100; below_mask = 4'b0001; end
      2'd2: begin above_mask = 4'b1000; below_mask = 4'b0011; end
      default: begin above_mask = 4'b0000; below_mask = 4'b0111; end
    endcase
  end

  assign hit       = |(pend_q & floor_bit);
  assign has_above = |(pend_q & above_mask);
  assign has_below = |(pend_q & below_mask);

  always_comb begin
    state_n  = state_q;
    cnt_n    = cnt_q;
    dir_n    = dir_q;
    set_mask = call_edge;
    clr_mask = 4'b0000;
    case (state_q)
      S_IDLE: begin
        if (hit) begin
          clr_mask = floor_bit;
          cnt_n    = DWELL_LD;
          state_n  = S_DOOR;
        end else if (has_above && (dir_q || !has_below)) begin
          dir_n   = 1'b1;
          state_n = S_STEP;
        end else if (has_below) begin
          dir_n   = 1'b0;
          state_n = S_STEP;
        end
      end
      S_DOOR: begin
        // A re-press at the open floor only extends the dwell.
        set_mask = call_edge & ~floor_bit;
        if (|(call_edge & floor_bit)) begin
          cnt_n = DWELL_LD;
        end else if (cnt_q <= 8'd1) begin
          cnt_n   = 8'd0;
          state_n = S_IDLE;
        end else begin
          cnt_n = cnt_q - 8'd1;
        end
      end
      S_STEP: begin
        cnt_n   = STEP_LD;
        state_n = S_SETTLE;
      end
      default: begin
        if (cnt_q > 8'd1) begin
          cnt_n = cnt_q - 8'd1;
        end else begin
          cnt_n = 8'd0;
          if (hit) begin
            clr_mask = floor_bit;
            cnt_n    = DWELL_LD;
            state_n  = S_DOOR;
          end else if (dir_q ? has_above : has_below) begin
            state_n = S_STEP;
          end else begin
            state_n = S_IDLE;
          end
        end
      end
    endcase

    // Never command a move past either end of the shaft.
    move_ok = dir_n ? (bus.floor != 2'd3) : (bus.floor != 2'd0);
    if (state_n == S_STEP && !move_ok) begin
      state_n = S_IDLE;
    end

    pend_n = (pend_q | set_mask) & ~clr_mask;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= S_IDLE;
      cnt_q   <= 8'd0;
      pend_q  <= 4'b0000;
      dir_q   <= 1'b1;
      u_q     <= 1'b0;
      d_q     <= 1'b0;
      door_q  <= 1'b0;
      prev_q  <= 4'b0000;
      armed_q <= 4'b0000;
    end else begin
      state_q <= state_n;
      cnt_q   <= cnt_n;
      pend_q  <= pend_n;
      dir_q   <= dir_n;
      u_q     <= (state_n == S_STEP) && dir_n;
      d_q     <= (state_n == S_STEP) && !dir_n;
      door_q  <= (state_n == S_DOOR);
      prev_q  <= call_c;
      armed_q <= armed_q | ~call_c;
    end
  end

  assign bus.u         = u_q;
  assign bus.d         = d_q;
  assign bus.pending   = pend_q;
  assign bus.door_open = door_q;
  assign bus.dir_up    = dir_q;
  assign bus.state     = state_q;
endmodule

// File: doc/elev_req_ctrl.md
ELEV_REQ_CTRL -- requirements
Module: elev_req_ctrl

Interface
REQ-001 Parameter DWELL_CYCLES, default 8: number of cycles door_open stays high per floor stop (legal range 1..255).
REQ-002 Parameter STEP_CYCLES, default 4: cycles waited after each u/d pulse before floor is re-evaluated (legal range 1..255).
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, synchronous, active-low.
REQ-005 call  input  4  raw hall/car call buttons, bit i = floor i (bit 0 = ground); level, asynchronous when ELEV_REQ_CTRL_CALL_SYNC_EN is defined.
REQ-006 floor  input  2  current floor from downstream elevator FSM, binary 0..3.
REQ-007 u  output  1  single-cycle "move up one floor" pulse to downstream FSM.
REQ-008 d  output  1  single-cycle "move down one floor" pulse to downstream FSM.
REQ-009 pending  output  4  latched outstanding requests, bit i = floor i.
REQ-010 door_open  output  1  high while stopped at a served floor.
REQ-011 dir_up  output  1  current sweep direction, 1 = up, 0 = down.

Function
REQ-012 Rising edge on conditioned call[i] SHALL set pending[i]; a held level SHALL NOT re-set it after it has been cleared.
REQ-013 States SHALL be IDLE, DOOR, STEP, SETTLE; all outputs registered.
REQ-014 IDLE: pending[floor]=1 -> clear pending[floor], load dwell counter with DWELL_CYCLES, go DOOR; else any pending above floor and (dir_up=1 or none below) -> dir_up=1, go STEP; else any pending below -> dir_up=0, go STEP; else stay.
REQ-015 DOOR: door_open=1; counter decrements each cycle; at 0 go IDLE with door_open=0 on the next cycle.
REQ-016 DOOR: call edge for current floor SHALL reload the dwell counter and SHALL NOT set pending[floor].
REQ-017 STEP: exactly one cycle; u=1 if dir_up=1, else d=1; load step counter with STEP_CYCLES; go SETTLE.
REQ-018 SETTLE: counter decrements; at 0 evaluate: pending[floor]=1 -> clear and go DOOR; else pending remaining in dir_up direction -> STEP; else IDLE.
REQ-019 u and d SHALL never be high in the same cycle; u SHALL never assert when floor=3, d never when floor=0 (STEP falls back to IDLE instead).
REQ-020 Call edge and clear for the same floor in the same cycle: clear wins, pending bit stays 0.
REQ-021 Counters SHALL be wide enough for 255 without wrap; no counter underflows below 0.

Reset
REQ-022 rst=0 at a rising edge SHALL force state IDLE, u=0, d=0, door_open=0, pending=4'b0000, dir_up=1, counters 0, synchronizer/edge flops 0, including mid-DOOR or mid-SETTLE.
REQ-023 Calls asserted during reset SHALL be ignored; a call already high when rst releases SHALL NOT register until it falls and rises again.

Configuration
REQ-024 Macro ELEV_REQ_CTRL_CALL_SYNC_EN defined: each call bit passes a 2-flop synchronizer before edge detection; pending[i] sets on the 3rd rising edge after call[i] goes high.
REQ-025 ELEV_REQ_CTRL_CALL_SYNC_EN undefined: call is treated as synchronous; pending[i] sets on the 1st rising edge at which call[i]=1 after being 0 the previous cycle.

Verification
REQ-026 Reset, floor=0, pulse call[2] -> pending=4'b0100, two u pulses spaced STEP_CYCLES+1 apart, at floor 2 pending=0, door_open high exactly 8 cycles, then IDLE.
REQ-027 floor=1, dir_up=1, call[3] and call[0] same cycle -> u serves floor 3 first (door), then two d pulses to floor 1 region and third to floor 0, door opens at 0.
REQ-028 In DOOR at floor 2, re-press call[2] at dwell count 2 -> door_open extends to 8 cycles from re-press, pending[2] stays 0.
REQ-029 floor=3, force dir_up=1 path with pending[3] set externally via call -> no u pulse ever issued; u&d never both 1 across 10k random call cycles.
REQ-030 rst=0 during SETTLE with pending=4'b1010 -> next cycle pending=0, u=d=door_open=0, dir_up=1; held call[1] ignored until released and re-pressed.
REQ-031 Run with and without ELEV_REQ_CTRL_CALL_SYNC_EN -> pending[i] rises 3 edges vs 1 edge after call[i] rises.
